mem_port_arbiter: RTL and testbench

Shares the single-ported data memory (memory_block) between two requesters: instruction fetch (IF) and data load/store (D).
- Sequences each access over a fixed number of memory cycles.
- Returns read data with a one-cycle valid pulse.
- Sits between the fetch/execute logic and memory_block in the multi-cycle MIPS build.

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and data (D) requesters.
// Optional MEM_ARB_RR_EN replaces D-priority/starvation arbitration with strict round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int LW = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state_q;
  logic [LW-1:0]     lat_q;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, if_rdata_q, d_rdata_q;
  logic              read_q, write_q, byte_q, if_valid_q, d_valid_q, busy_q;
  logic              if_win, d_win;
`ifdef MEM_ARB_RR_EN
  // owner_q is 1 when D owned the last access, so IF gets the next tie
  assign if_win = if_req & (~d_req | owner_q);
`else
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q;
  assign if_win = if_req & (~d_req | (starve_q == SW'(STARVE_MAX)));
`endif
  assign d_win     = d_req & ~if_win;
  assign if_gnt    = RST_N & (state_q == IDLE) & if_win;
  assign d_gnt     = RST_N & (state_q == IDLE) & d_win;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = read_q;
  assign mem_write = write_q;
  assign mem_byte  = byte_q;
  assign busy      = busy_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      byte_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifndef MEM_ARB_RR_EN
      starve_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (if_win | d_win) begin
          state_q <= ACCESS;
          busy_q  <= 1'b1;
          lat_q   <= LW'(MEM_LAT - 1);
          owner_q <= d_win;
          addr_q  <= d_win ? d_addr : if_addr;
          wdata_q <= d_win ? d_wdata : '0;
          read_q  <= ~(d_win & d_we);
          write_q <= d_win & d_we;
          byte_q  <= d_win & d_byte;
`ifndef MEM_ARB_RR_EN
          if (if_win) starve_q <= '0;
          else if (if_req && starve_q != SW'(STARVE_MAX)) starve_q <= starve_q + SW'(1);
`endif
        end
        ACCESS: if (lat_q == '0) begin
          if (read_q && !owner_q) if_rdata_q <= mem_rdata;
          if (read_q && owner_q) d_rdata_q <= mem_rdata;
          if_valid_q <= ~owner_q;
          d_valid_q  <= owner_q;
          addr_q     <= '0;
          wdata_q    <= '0;
          read_q     <= 1'b0;
          write_q    <= 1'b0;
          byte_q     <= 1'b0;
          state_q    <= RESP;
        end else begin
          lat_q <= lat_q - LW'(1);
        end
        RESP: begin
          if_valid_q <= 1'b0;
          d_valid_q  <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized requesters, reference arbiter model and scoreboard monitor.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 18, DATA_W = 32, MEM_LAT = 2, STARVE_MAX = 3;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic if_req = 0, d_req = 0, d_we = 0, d_byte = 0;
  logic [ADDR_W-1:0] if_addr = '0, d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0, mem_rdata = '0;
  logic if_gnt, if_valid, d_gnt, d_valid, mem_read, mem_write, mem_byte, busy;
  logic [DATA_W-1:0] if_rdata, d_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte(mem_byte), .mem_rdata(mem_rdata), .busy(busy));

  always #5 CLK = ~CLK;

  int tests = 0, fails = 0, cyc = 0;
  bit chk_en = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit d; bit we; bit bt;
    logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata;
    int gcyc; logic [DATA_W-1:0] rd;
  } txn_t;
  txn_t q[$];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // Reference arbiter: one access occupies the port for MEM_LAT+2 cycles from its grant.
  int next_free = 0, losses = 0;
  bit last_d = 0;
  always @(negedge CLK) if (chk_en) begin
    bit ew_if, ew_d;
    ew_if = 0;
    ew_d  = 0;
    if (cyc >= next_free) begin
`ifdef MEM_ARB_RR_EN
      ew_if = if_req && (!d_req || last_d);
`else
      ew_if = if_req && (!d_req || losses == STARVE_MAX);
`endif
      ew_d = d_req && !ew_if;
    end
    chk("if_gnt", if_gnt, ew_if);
    chk("d_gnt", d_gnt, ew_d);
    if (ew_if || ew_d) begin
      q.push_back('{ew_d, ew_d && d_we, ew_d && d_byte, ew_d ? d_addr : if_addr,
                    ew_d ? d_wdata : '0, cyc, '0});
      next_free = cyc + MEM_LAT + 2;
      last_d = ew_d;
      if (ew_if) losses = 0;
      else if (if_req && losses < STARVE_MAX) losses++;
    end
  end

  // Monitor: checks memory-side signals and pops the scoreboard on valid pulses.
  logic [DATA_W-1:0] exp_if_rd = '0, exp_d_rd = '0;
  always @(negedge CLK) if (chk_en) begin
    bit act, ev;
    #1;
    act = q.size() > 0 && cyc > q[0].gcyc && cyc <= q[0].gcyc + MEM_LAT;
    ev  = q.size() > 0 && cyc == q[0].gcyc + MEM_LAT + 1;
    chk("busy", busy, act || ev);
    if (act) begin
      chk("mem_read", mem_read, !q[0].we);
      chk("mem_write", mem_write, q[0].we);
      chk("mem_byte", mem_byte, q[0].bt);
      chk("mem_addr", mem_addr, q[0].addr);
      if (q[0].d) chk("mem_wdata", mem_wdata, q[0].wdata);
      if (cyc == q[0].gcyc + MEM_LAT)
        q[0].rd = q[0].we ? exp_d_rd : mem_rdata;
    end else begin
      chk("mem_idle", {mem_read, mem_write, mem_byte, mem_addr, mem_wdata}, 64'd0);
    end
    chk("if_valid", if_valid, ev && !q[0].d);
    chk("d_valid", d_valid, ev && q[0].d);
    if (ev) begin
      if (q[0].d) exp_d_rd = q[0].rd;
      else exp_if_rd = q[0].rd;
      chk("if_rdata", if_rdata, exp_if_rd);
      chk("d_rdata", d_rdata, exp_d_rd);
      void'(q.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit gi, gd;
    if_req = 1; d_req = 1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_gnt", {if_gnt, d_gnt}, 0);
    chk("rst_outs", {if_valid, d_valid, mem_read, mem_write, mem_byte, busy, mem_addr}, 0);
    chk("rst_data", {if_rdata, d_rdata}, 0);
    if_req = 0; d_req = 0;
    RST_N = 1;
    chk_en = 1;
    for (int i = 0; i < 1600; i++) begin
      @(negedge CLK);
      gi = if_gnt;
      gd = d_gnt;
      @(posedge CLK);
      #1;
      mem_rdata = $urandom;
      if (gi) if_req = 0;
      if (gd) d_req = 0;
      if (i < 60) begin
        if_req = 1; d_req = 1;
        if_addr = ADDR_W'($urandom); d_addr = ADDR_W'($urandom);
        d_we = 1'($urandom); d_byte = 1'($urandom); d_wdata = $urandom;
      end else begin
        if (!if_req && $urandom_range(3) == 0) begin
          if_req = 1; if_addr = ADDR_W'($urandom);
        end else if (if_req && $urandom_range(40) == 0) if_req = 0;
        if (!d_req && $urandom_range(2) == 0) begin
          d_req = 1; d_addr = ADDR_W'($urandom); d_we = 1'($urandom);
          d_byte = 1'($urandom); d_wdata = $urandom;
        end else if (d_req && $urandom_range(40) == 0) d_req = 0;
      end
    end
    if_req = 0; d_req = 0;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge CLK);
    chk("drain", q.size(), 0);
    repeat (2) @(posedge CLK);
    #1;
    chk_en = 0;
    // Reset in the middle of an IF access.
    if_req = 1; if_addr = 18'h10;
    @(negedge CLK);
    chk("rt_gnt", if_gnt, 1);
    @(posedge CLK);
    #1;
    if_req = 0;
    @(negedge CLK);
    chk("rt_access", {mem_read, mem_addr}, {1'b1, 18'h10});
    #1;
    RST_N = 0;
    #1;
    chk("rt_outs", {if_valid, d_valid, mem_read, mem_write, mem_byte, busy, mem_addr, if_gnt, d_gnt}, 0);
    chk("rt_data", {if_rdata, d_rdata, mem_wdata}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rt_hold", {if_valid, busy, mem_read}, 0);
    end
    @(posedge CLK);
    #1;
    RST_N = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("rt_idle", {if_valid, d_valid, busy, mem_read}, 0);
    end
    @(posedge CLK);
    #1;
    if_req = 1; d_req = 1;
    @(negedge CLK);
    chk("rt_first_tie", {if_gnt, d_gnt}, 2'b01);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
